// File: rtl/lsu_mem_master.sv
// Load/store initiator: turns one RV32I load/store into registered memory
// read/write transactions, with read-modify-write for SB/SH and a read timeout.
module lsu_mem_master #(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_re,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  input  logic        o_mem_re
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD   = 3'd1;
  localparam logic [2:0] WAIT = 3'd2;
  localparam logic [2:0] WR   = 3'd3;
  localparam logic [2:0] RESP = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            is_store_q, is_store_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [15:0]     wdata_q, wdata_d;
  logic            mem_re_q, mem_re_d;
  logic            mem_we_q, mem_we_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic [31:0]     mem_data_q, mem_data_d;
  logic            resp_valid_q, resp_valid_d;
  logic            resp_err_q, resp_err_d;
  logic [31:0]     resp_rdata_q, resp_rdata_d;

  logic        legal;
  logic [31:0] load_ext;

  always_comb begin
    legal = 1'b0;
    if (req_we) begin
      legal = (req_funct3 <= 3'd2);
    end else begin
      case (req_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
        default:                                legal = 1'b0;
      endcase
    end
  end

  // The read word is already aligned to the request address, so extension
  // only ever looks at the low byte or half-word.
  always_comb begin
    case (funct3_q)
      3'b000:  load_ext = {{24{mem_data_out[7]}}, mem_data_out[7:0]};
      3'b100:  load_ext = {24'b0, mem_data_out[7:0]};
      3'b001:  load_ext = {{16{mem_data_out[15]}}, mem_data_out[15:0]};
      3'b101:  load_ext = {16'b0, mem_data_out[15:0]};
      default: load_ext = mem_data_out;
    endcase
  end

  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    is_store_d   = is_store_q;
    funct3_d     = funct3_q;
    wdata_d      = wdata_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    mem_re_d     = 1'b0;
    mem_we_d     = 1'b0;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = 32'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          is_store_d = req_we;
          funct3_d   = req_funct3;
          wdata_d    = req_wdata[15:0];
          if (!legal) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (req_we && req_funct3 == 3'b010) begin
            state_d    = WR;
            mem_we_d   = 1'b1;
            mem_addr_d = req_addr;
            mem_data_d = req_wdata;
          end else begin
            state_d    = RD;
            mem_re_d   = 1'b1;
            mem_addr_d = req_addr;
          end
        end
      end
      RD: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        if (o_mem_re) begin
          if (!is_store_q) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = load_ext;
          end else begin
            state_d    = WR;
            mem_we_d   = 1'b1;
            mem_data_d = funct3_q[0] ? {mem_data_out[31:16], wdata_q}
                                     : {mem_data_out[31:8], wdata_q[7:0]};
          end
        end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WR: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      is_store_q   <= 1'b0;
      funct3_q     <= 3'b0;
      wdata_q      <= 16'b0;
      mem_re_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'b0;
      mem_data_q   <= 32'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      is_store_q   <= is_store_d;
      funct3_q     <= funct3_d;
      wdata_q      <= wdata_d;
      mem_re_q     <= mem_re_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign mem_re      = mem_re_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_data_in = mem_data_q;
  assign resp_valid  = resp_valid_q;
  assign resp_err    = resp_err_q;
  assign resp_rdata  = resp_rdata_q;

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator that sits between the execute stage and the byte-addressed, little-endian unified memory.
- Converts one RV32I load/store request into mem_re/mem_we transactions and waits for the memory's registered read-valid (o_mem_re).
- Returns a sign- or zero-extended load result.
- The memory only writes full 4-byte words, so SB/SH are done as read-modify-write.

Parameters:
TIMEOUT, 16, max WAIT cycles for o_mem_re before an error response (>=2)
TO_W, 5, width of the timeout counter (must hold TIMEOUT)

Ports:
clk  input  1  system clock, all logic on posedge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  pipeline request strobe
req_ready  output  1  high only in IDLE; a transfer occurs when req_valid & req_ready at a posedge
req_we  input  1  1=store, 0=load
req_funct3  input  3  RV32I funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010)
req_addr  input  32  byte address, any alignment
req_wdata  input  32  store data, low bytes used for SB/SH
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  extended load data; 0 for stores/errors
resp_err  output  1  valid with resp_valid; 1=illegal funct3 or timeout
mem_re  output  1  memory read enable, registered
mem_we  output  1  memory write enable, registered
mem_addr  output  32  memory byte address, registered
mem_data_in  output  32  word to memory, registered
mem_data_out  input  32  read word from memory, bytes {a+3,a+2,a+1,a}
o_mem_re  input  1  memory read-valid, high the cycle after the memory samples mem_re

Behaviour:
- Reset (async, rst_n low) forces:
  - state IDLE, timeout counter 0
  - mem_re, mem_we = 0; mem_addr, mem_data_in = 0
  - resp_valid, resp_err = 0; resp_rdata = 0
- req_ready = (state==IDLE), so it reads 1 during reset, but requests are ignored while rst_n is low.
- Request fields are latched on accept and are don't-care afterwards.
- States: IDLE, RD, WAIT, WR, RESP. Exactly one of mem_re/mem_we is high: mem_re only in RD, mem_we only in WR.
- IDLE, on accept:
  - load with legal funct3 -> RD; mem_addr = req_addr
  - SB/SH -> RD
  - SW -> WR; mem_data_in = req_wdata
  - illegal funct3 (load 011/110/111, store 011-111) -> RESP with resp_err=1, no memory access
- RD (mem_re=1) -> WAIT unconditionally; counter cleared.
- WAIT, when o_mem_re=1, mem_data_out is sampled that cycle:
  - load -> RESP, with resp_rdata as follows:
    - LB: sign-extend [7:0]
    - LBU: zero-extend [7:0]
    - LH: sign-extend [15:0]
    - LHU: zero-extend [15:0]
    - LW: full word
  - SB -> WR; mem_data_in = {rd[31:8], wdata[7:0]}
  - SH -> WR; mem_data_in = {rd[31:16], wdata[15:0]}
- WAIT, when o_mem_re=0: counter increments. When counter == TIMEOUT-1 with o_mem_re still 0 -> RESP with resp_err=1; no write is issued, even for SB/SH.
- WR (mem_we=1) -> RESP.
- RESP: resp_valid=1 for exactly one cycle, then -> IDLE. The earliest next accept is the cycle after RESP.
- Latency, with accept in cycle N:
  - load: mem_re N+1, o_mem_re N+2, resp_valid N+3
  - SW: mem_we N+1, resp_valid N+2
  - SB/SH: mem_re N+1, mem_we N+3, resp_valid N+4
  - illegal: resp_valid N+1
- o_mem_re high outside WAIT is ignored.
- mem_addr holds the latched address for the whole transaction and through RMW. Address arithmetic beyond it (addr+1..+3 wrapping mod 2^32) is the memory's concern.
- Reset mid-transaction:
  - any state returns to IDLE immediately
  - mem_we drops asynchronously, so no write takes effect unless mem_we was already sampled at an earlier edge
  - no resp_valid is produced for the aborted request

Test Plan:
1. Preload 0x100..0x103 = BB AA 99 88. LB 0x103 -> resp_rdata 0xFFFFFF88 at N+3. LBU 0x103 -> 0x00000088. resp_err=0 in both.
2. LH 0x102 -> 0xFFFF8899. LHU 0x100 -> 0x0000AABB. LW 0x100 -> 0x8899AABB. LW 0x101 (unaligned) -> {mem[0x104], 0x8899AA}.
3. SW 0x200 data 0x12345678 -> mem_we=1 only in N+1 with mem_addr 0x200 and mem_data_in 0x12345678, resp_valid at N+2. Then LW 0x200 -> 0x12345678.
4. SB 0x100 data 0xFFFFFFCC -> mem_re N+1, mem_we N+3 with 0x8899AACC, resp N+4. Then SH 0x100 data 0x0000DEAD -> write 0x8899DEAD.
5. Tie o_mem_re=0 and issue LW -> resp_err=1, resp_rdata=0 after 16 WAIT cycles. Also LW with funct3 011 -> resp_err=1 at N+1, mem_re/mem_we never asserted.
6. Assert rst_n=0 during the WAIT state of an SB -> all outputs 0 immediately, no mem_we, no resp_valid; the first request after release completes normally.
